multiplier_control_unit: RTL and testbench

MULTIPLIER_CONTROL_UNIT -- requirements
Module: multiplier_control_unit

---
 rtl/mult_pkg.sv | 40 ++++
 rtl/bin16_to_bcd_seq.sv | 49 ++++
 rtl/multiplier_control_unit.sv | 123 ++++++++++++
 tb/tb_multiplier_control_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Purpose : shared state encoding, widths and datapath helpers for the signed multiplier.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, operand/product/BCD widths, iteration counts,
//           abs8() magnitude helper, dd_step() one double-dabble iteration.
package mult_pkg;

  localparam int OPERAND_W  = 8;
  localparam int PRODUCT_W  = 16;
  localparam int BCD_W      = 20;
  localparam int MULT_ITERS = 8;
  localparam int CONV_ITERS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MULT,
    ST_CONVERT,
    ST_DONE
  } state_t;

  // Unsigned magnitude of a two's-complement operand; -128 maps to 8'h80 (128).
  function automatic logic [OPERAND_W-1:0] abs8(input logic [OPERAND_W-1:0] v);
    return v[OPERAND_W-1] ? (~v + OPERAND_W'(1)) : v;
  endfunction

  // One double-dabble iteration on {bcd digits, binary}: add 3 to every digit
  // >= 5, then shift the whole vector left by one.
  function automatic logic [BCD_W+PRODUCT_W-1:0] dd_step(input logic [BCD_W+PRODUCT_W-1:0] v);
    logic [BCD_W+PRODUCT_W-1:0] t;
    t = v;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (t[PRODUCT_W + 4*d +: 4] >= 4'd5) begin
        t[PRODUCT_W + 4*d +: 4] = t[PRODUCT_W + 4*d +: 4] + 4'd3;
      end
    end
    return {t[BCD_W+PRODUCT_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin16_to_bcd_seq.sv
// Purpose : sequential 16-bit binary to 5-digit BCD converter (double dabble).
// Latency : 16 cycles; first step on the i_start edge, o_done high in the 16th cycle,
//           o_bcd updated on the edge that ends that cycle. No backpressure; i_start
//           is only expected while idle.
// Ports   : clk, rst_n (sync, active-low), i_start, i_bin[15:0] -> o_done, o_bcd[19:0].
module bin16_to_bcd_seq
  import mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [PRODUCT_W-1:0] i_bin,
  output logic                 o_done,
  output logic [BCD_W-1:0]     o_bcd
);

  logic [BCD_W+PRODUCT_W-1:0] r_work;
  logic [BCD_W-1:0]           r_bcd;
  logic [3:0]                 r_cnt;
  logic                       r_busy;
  logic [BCD_W+PRODUCT_W-1:0] w_step;

  // The load and the first iteration share the start edge so that exactly
  // CONV_ITERS edges elapse from start to result.
  assign w_step = dd_step(i_start ? {{BCD_W{1'b0}}, i_bin} : r_work);
  assign o_done = r_busy && (r_cnt == 4'(CONV_ITERS - 1));
  assign o_bcd  = r_bcd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_work <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_work <= w_step;
      r_cnt  <= 4'd1;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_work <= w_step;
      r_cnt  <= r_cnt + 4'd1;
      if (o_done) begin
        r_busy <= 1'b0;
        r_bcd  <= w_step[BCD_W+PRODUCT_W-1:PRODUCT_W];
      end
    end
  end

endmodule

// File: rtl/multiplier_control_unit.sv
// Purpose : signed 8x8 shift-add multiplier with sequential BCD conversion of |product|.
// Latency : fixed; busy for 25 cycles after start acceptance, done pulse in cycle 26.
// Backpressure: none; start is accepted only in IDLE and dropped in every other state.
// Ports   : clk, rst_n (sync, active-low), start, multiplicand[7:0], multiplier[7:0]
//           -> busy, done, product[15:0], sign, bcd[19:0], bcd_valid.
module multiplier_control_unit
  import mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OPERAND_W-1:0] multiplicand,
  input  logic [OPERAND_W-1:0] multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [PRODUCT_W-1:0] product,
  output logic                 sign,
  output logic [BCD_W-1:0]     bcd,
  output logic                 bcd_valid
);

  state_t                 r_state, w_next;
  logic [OPERAND_W-1:0]   r_a, r_b;
  logic [PRODUCT_W-1:0]   r_mcand;   // multiplicand magnitude, shifted left each step
  logic [OPERAND_W-1:0]   r_mplier;  // multiplier magnitude, shifted right each step
  logic [PRODUCT_W-1:0]   r_acc;
  logic                   r_neg;
  logic [2:0]             r_cnt;
  logic                   r_conv_go;
  logic [PRODUCT_W-1:0]   r_product;
  logic                   r_sign;
  logic                   r_bcd_valid;
  logic                   w_mult_last;
  logic                   w_conv_done;
  logic [BCD_W-1:0]       w_bcd;

  assign w_mult_last = (r_cnt == 3'(MULT_ITERS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_LOAD;
      ST_LOAD:    begin busy = 1'b1; w_next = ST_MULT; end
      ST_MULT:    begin busy = 1'b1; if (w_mult_last) w_next = ST_CONVERT; end
      ST_CONVERT: begin busy = 1'b1; if (w_conv_done) w_next = ST_DONE; end
      ST_DONE:    begin done = 1'b1; w_next = ST_IDLE; end
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_conv_go   <= 1'b0;
      r_product   <= '0;
      r_sign      <= 1'b0;
      r_bcd_valid <= 1'b0;
    end else begin
      r_conv_go <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a         <= multiplicand;
            r_b         <= multiplier;
            // Dropped on the accepting edge so it already reads 0 during LOAD.
            r_bcd_valid <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_mcand  <= {{(PRODUCT_W-OPERAND_W){1'b0}}, abs8(r_a)};
          r_mplier <= abs8(r_b);
          r_neg    <= r_a[OPERAND_W-1] ^ r_b[OPERAND_W-1];
          r_acc    <= '0;
          r_cnt    <= '0;
        end
        ST_MULT: begin
          if (r_mplier[0]) r_acc <= r_acc + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 3'd1;
          // Converter starts the cycle after the final accumulate lands.
          if (w_mult_last) r_conv_go <= 1'b1;
        end
        ST_CONVERT: begin
          if (w_conv_done) begin
            r_product   <= r_neg ? (~r_acc + PRODUCT_W'(1)) : r_acc;
            r_sign      <= r_neg && (r_acc != '0);  // no negative zero
            r_bcd_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  bin16_to_bcd_seq u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (r_conv_go),
    .i_bin   (r_acc),
    .o_done  (w_conv_done),
    .o_bcd   (w_bcd)
  );

  assign product   = r_product;
  assign sign      = r_sign;
  assign bcd       = w_bcd;
  assign bcd_valid = r_bcd_valid;

endmodule

// File: tb/tb_multiplier_control_unit.sv
// Purpose : directed self-checking bench for multiplier_control_unit with a result scoreboard.
// Latency : expects done exactly 26 cycles after the start-accepting edge.
// Backpressure: n/a.
module tb_multiplier_control_unit;

  typedef struct packed {
    logic [15:0] p;
    logic        s;
    logic [19:0] bcd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  multiplicand, multiplier;
  logic        busy, done, sign, bcd_valid;
  logic [15:0] product;
  logic [19:0] bcd;

  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  multiplier_control_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .sign         (sign),
    .bcd          (bcd),
    .bcd_valid    (bcd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Reference built from integer arithmetic and decimal digit extraction.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    int   p, m;
    exp_t e;
    p     = int'($signed(a)) * int'($signed(b));
    m     = (p < 0) ? -p : p;
    e.p   = 16'(p);
    e.s   = (p < 0);
    e.bcd = {4'(m / 10000), 4'((m / 1000) % 10), 4'((m / 100) % 10),
             4'((m / 10) % 10), 4'(m % 10)};
    return e;
  endfunction

  // Issues one operation; repulse = cycle index (1..26) at which start is
  // driven again, 0 for none.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int repulse,
                        input exp_t ex);
    exp_t e;
    int   done_cyc;
    e = '0;
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    sb.push_back(ex);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = 8'($urandom);
    multiplier   = 8'($urandom);
    done_cyc     = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      chk("busy", 32'(busy), 32'(c <= 25));
      if (c <= 25) chk("bcd_valid_low", 32'(bcd_valid), 32'(0));
      if (done === 1'b1) begin
        done_cyc = c;
        e = sb.pop_front();
        chk("product",   32'(product),   32'(e.p));
        chk("sign",      32'(sign),      32'(e.s));
        chk("bcd",       32'(bcd),       32'(e.bcd));
        chk("bcd_valid", 32'(bcd_valid), 32'(1));
      end
      start        = (c == repulse);
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_cycle", 32'(done_cyc), 32'(26));
    chk("done_single", 32'(done), 32'(0));
    chk("idle_after", 32'(busy), 32'(0));
    repeat (3) @(negedge clk);
    chk("hold_product",   32'(product),   32'(e.p));
    chk("hold_bcd",       32'(bcd),       32'(e.bcd));
    chk("hold_bcd_valid", 32'(bcd_valid), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_done",      32'(done),      32'(0));
    chk("rst_bcd_valid", 32'(bcd_valid), 32'(0));
    chk("rst_sign",      32'(sign),      32'(0));
    chk("rst_product",   32'(product),   32'(0));
    chk("rst_bcd",       32'(bcd),       32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors; 7*-3 also re-pulses start mid-MULT, 127*-128 at done.
    run_op(8'd7,   8'hFD, 5,  {16'hFFEB, 1'b1, 20'h00021});
    run_op(8'h80,  8'h80, 0,  {16'h4000, 1'b0, 20'h16384});
    run_op(8'd127, 8'h80, 26, {16'hC080, 1'b1, 20'h16256});
    run_op(8'd0,   8'hFB, 0,  {16'h0000, 1'b0, 20'h00000});
    run_op(8'hFF,  8'hFF, 0,  model(8'hFF, 8'hFF));
    for (int i = 0; i < 3; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, 0, model(ra, rb));
    end

    // Abort in the 5th CONVERT cycle (cycle 14 after acceptance).
    @(negedge clk);
    multiplicand = 8'd100;
    multiplier   = 8'd100;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'(1));
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    chk("abort_busy",      32'(busy),      32'(0));
    chk("abort_done",      32'(done),      32'(0));
    chk("abort_bcd_valid", 32'(bcd_valid), 32'(0));
    chk("abort_sign",      32'(sign),      32'(0));
    chk("abort_product",   32'(product),   32'(0));
    chk("abort_bcd",       32'(bcd),       32'(0));
    for (int c = 0; c < 20; c++) begin
      chk("abort_no_done", 32'(done), 32'(0));
      @(negedge clk);
    end
    run_op(8'hF6, 8'd25, 0, model(8'hF6, 8'd25));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
